// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the byte-serial load/store controller: width
// constants, request size encodings, FSM state encoding and small helpers.
package mem_ctrl_pkg;

  localparam int          RegLen    = 32;
  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BYTE_W = 8;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    STORE = 3'd1,
    LOAD  = 3'd2,
    LAST  = 3'd3,
    DONE  = 3'd4
  } state_e;

  // Number of bytes moved by a request; encoding 3 behaves as a word.
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    logic [2:0] n;
    case (size)
      SIZE_BYTE: n = 3'd1;
      SIZE_HALF: n = 3'd2;
      default:   n = 3'd4;
    endcase
    return n;
  endfunction

  // True when a half/word request is not naturally aligned.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] addr_lo);
    logic mis;
    case (size)
      SIZE_BYTE: mis = 1'b0;
      SIZE_HALF: mis = addr_lo[0];
      default:   mis = (addr_lo != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Byte-serial memory access controller between the pipeline MEM stage and a
// byte-wide synchronous RAM (1-cycle read latency). Loads/stores of 1, 2 or
// 4 bytes are sequenced one byte per cycle, little-endian.
// Optional build macro: MEM_CTRL_MISALIGN_TRAP_EN -- when defined, misaligned
// half/word requests skip the RAM and complete with err_o=1.
module mem_ctrl
  import mem_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid_i,
  input  logic                req_we_i,
  input  logic [1:0]          req_size_i,
  input  logic                req_signed_i,
  input  logic [ADDR_W-1:0]   req_addr_i,
  input  logic [DATA_W-1:0]   req_wdata_i,
  output logic                req_ready_o,
  output logic                done_o,
  output logic [DATA_W-1:0]   rdata_o,
  output logic                err_o,
  output logic                stall_o,
  output logic [ADDR_W-1:0]   ram_addr_o,
  output logic [BYTE_W-1:0]   ram_wdata_o,
  output logic                ram_we_o,
  input  logic [BYTE_W-1:0]   ram_rdata_i
);

  state_e              state_q, state_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [1:0]          size_q, size_d;
  logic                signed_q, signed_d;
  logic [DATA_W-1:0]   buf_q, buf_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [2:0]          n_bytes;
  logic                last_byte;
  logic [1:0]          cap_idx;
`ifdef MEM_CTRL_MISALIGN_TRAP_EN
  logic                err_q, err_d;
`endif

  // Extend the assembled little-endian bytes to a full word.
  function automatic logic [DATA_W-1:0] extend_load(input logic [DATA_W-1:0] raw,
                                                    input logic [1:0] size,
                                                    input logic sgn);
    logic [DATA_W-1:0] res;
    case (size)
      SIZE_BYTE: res = {{24{sgn & raw[7]}}, raw[7:0]};
      SIZE_HALF: res = {{16{sgn & raw[15]}}, raw[15:0]};
      default:   res = raw;
    endcase
    return res;
  endfunction

  assign n_bytes   = size_bytes(size_q);
  assign last_byte = (cnt_q == (n_bytes - 3'd1));
  // Read data arriving now belongs to the address issued one cycle earlier.
  assign cap_idx   = cnt_q[1:0] - 2'd1;

  // Next-state and datapath update.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    size_d   = size_q;
    signed_d = signed_q;
    buf_d    = buf_q;
    rdata_d  = rdata_q;
`ifdef MEM_CTRL_MISALIGN_TRAP_EN
    err_d    = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          addr_d   = req_addr_i;
          wdata_d  = req_wdata_i;
          size_d   = req_size_i;
          signed_d = req_signed_i;
          cnt_d    = 3'd0;
          buf_d    = ZERO_WORD;
          state_d  = req_we_i ? STORE : LOAD;
`ifdef MEM_CTRL_MISALIGN_TRAP_EN
          err_d    = is_misaligned(req_size_i, req_addr_i[1:0]);
          if (err_d) begin
            state_d = DONE;
          end
`endif
        end
      end
      STORE: begin
        cnt_d = cnt_q + 3'd1;
        if (last_byte) begin
          state_d = DONE;
        end
      end
      LOAD: begin
        if (cnt_q != 3'd0) begin
          buf_d[{cap_idx, 3'b000} +: BYTE_W] = ram_rdata_i;
        end
        cnt_d = cnt_q + 3'd1;
        if (last_byte) begin
          state_d = LAST;
        end
      end
      LAST: begin
        buf_d[{cap_idx, 3'b000} +: BYTE_W] = ram_rdata_i;
        rdata_d = extend_load(buf_d, size_q, signed_q);
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= 3'd0;
      addr_q   <= ZERO_WORD;
      wdata_q  <= ZERO_WORD;
      size_q   <= SIZE_BYTE;
      signed_q <= 1'b0;
      buf_q    <= ZERO_WORD;
      rdata_q  <= ZERO_WORD;
`ifdef MEM_CTRL_MISALIGN_TRAP_EN
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      size_q   <= size_d;
      signed_q <= signed_d;
      buf_q    <= buf_d;
      rdata_q  <= rdata_d;
`ifdef MEM_CTRL_MISALIGN_TRAP_EN
      err_q    <= err_d;
`endif
    end
  end

  // Outputs decoded from the current state; all go quiet in IDLE.
  always_comb begin
    req_ready_o = (state_q == IDLE);
    done_o      = (state_q == DONE);
    stall_o     = (req_valid_i & (state_q != IDLE)) |
                  ((state_q != IDLE) & (state_q != DONE));
    ram_we_o    = (state_q == STORE);
    ram_addr_o  = ZERO_WORD;
    ram_wdata_o = '0;
    if ((state_q == STORE) || (state_q == LOAD)) begin
      ram_addr_o = addr_q + {29'd0, cnt_q};
    end
    if (state_q == STORE) begin
      ram_wdata_o = wdata_q[{cnt_q[1:0], 3'b000} +: BYTE_W];
    end
  end

  assign rdata_o = rdata_q;

`ifdef MEM_CTRL_MISALIGN_TRAP_EN
  assign err_o = err_q & (state_q == DONE);
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: byte-wide RAM model plus a reference
// memory image; each transaction is checked cycle by cycle against timing
// and data derived from the access rules.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid_i = 1'b0;
  logic        req_we_i = 1'b0;
  logic [1:0]  req_size_i = 2'd0;
  logic        req_signed_i = 1'b0;
  logic [31:0] req_addr_i = 32'h0;
  logic [31:0] req_wdata_i = 32'h0;
  logic        req_ready_o, done_o, err_o, stall_o, ram_we_o;
  logic [31:0] rdata_o, ram_addr_o;
  logic [7:0]  ram_wdata_o;
  logic [7:0]  ram_rdata_i = 8'h00;

  logic [7:0]  ram     [logic [31:0]];
  logic [7:0]  ref_mem [logic [31:0]];
  logic [31:0] exp_rdata = 32'h0;
  int          n_pass  = 0;
  int          n_total = 0;
  int          op_id   = 0;

  mem_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid_i  (req_valid_i),
    .req_we_i     (req_we_i),
    .req_size_i   (req_size_i),
    .req_signed_i (req_signed_i),
    .req_addr_i   (req_addr_i),
    .req_wdata_i  (req_wdata_i),
    .req_ready_o  (req_ready_o),
    .done_o       (done_o),
    .rdata_o      (rdata_o),
    .err_o        (err_o),
    .stall_o      (stall_o),
    .ram_addr_o   (ram_addr_o),
    .ram_wdata_o  (ram_wdata_o),
    .ram_we_o     (ram_we_o),
    .ram_rdata_i  (ram_rdata_i)
  );

  always #5 clk = ~clk;

  // Byte-wide RAM with one cycle of read latency.
  always @(posedge clk) begin
    ram_rdata_i <= ram.exists(ram_addr_o) ? ram[ram_addr_o] : 8'h00;
    if (ram_we_o) ram[ram_addr_o] = ram_wdata_o;
  end

  function automatic logic [7:0] rd_ref(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
  endfunction

  task automatic preload(input logic [31:0] a, input logic [7:0] d);
    ram[a] = d;
    ref_mem[a] = d;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL op%0d %s: got %h expected %h", op_id, tag, obs, exp);
  endtask

  // One complete transaction, presented in an IDLE cycle and checked each cycle.
  task automatic do_op(input logic we, input logic [1:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wdata, input bit hold);
    int n;
    bit trap;
    int exp_done;
    logic [31:0] exp_res;
    logic [31:0] prev;
    n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    trap = 1'b0;
`ifdef MEM_CTRL_MISALIGN_TRAP_EN
    trap = (size == 2'd1 && addr[0]) || (size >= 2'd2 && addr[1:0] != 2'b00);
`endif
    exp_done = trap ? 1 : (we ? n + 1 : n + 2);
    prev = exp_rdata;
    exp_res = prev;
    if (!we && !trap) begin
      exp_res = 32'h0;
      for (int i = 0; i < n; i++) exp_res |= {24'h0, rd_ref(addr + i)} << (8 * i);
      if (sgn && exp_res[8 * n - 1]) exp_res |= ~((32'h1 << (8 * n)) - 32'h1);
    end

    @(posedge clk); #1;
    req_valid_i = 1'b1; req_we_i = we; req_size_i = size;
    req_signed_i = sgn; req_addr_i = addr; req_wdata_i = wdata;
    @(negedge clk);
    check("ready_idle", {31'h0, req_ready_o}, 32'h1);
    @(posedge clk); #1;
    if (!hold) begin
      req_valid_i = 1'b0;
      req_we_i = 1'($urandom); req_size_i = 2'($urandom); req_signed_i = 1'($urandom);
      req_addr_i = $urandom; req_wdata_i = $urandom;
    end
    for (int k = 1; k <= exp_done; k++) begin
      @(negedge clk);
      if (k < exp_done) begin
        check("done_busy", {31'h0, done_o}, 32'h0);
        check("ready_busy", {31'h0, req_ready_o}, 32'h0);
        check("stall_busy", {31'h0, stall_o}, 32'h1);
        check("rdata_hold", rdata_o, prev);
        if (!trap && k <= n) begin
          check("ram_addr", ram_addr_o, addr + k - 1);
          check("ram_we", {31'h0, ram_we_o}, {31'h0, we});
          if (we) check("ram_wdata", {24'h0, ram_wdata_o}, (wdata >> (8 * (k - 1))) & 32'hFF);
        end else begin
          check("ram_we_off", {31'h0, ram_we_o}, 32'h0);
        end
      end else begin
        check("done", {31'h0, done_o}, 32'h1);
        check("err", {31'h0, err_o}, {31'h0, trap});
        check("rdata", rdata_o, exp_res);
        check("stall_done", {31'h0, stall_o}, {31'h0, hold});
        check("ram_we_done", {31'h0, ram_we_o}, 32'h0);
      end
    end
    if (we && !trap) begin
      for (int i = 0; i < n; i++) ref_mem[addr + i] = wdata[8 * i +: 8];
    end
    exp_rdata = exp_res;
    $display("op %0d: %s size=%0d signed=%0d addr=%h wdata=%h rdata=%h err=%0d",
             op_id, we ? "store" : "load ", size, sgn, addr, wdata, rdata_o, err_o);
    op_id++;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic        r_we;
    logic [1:0]  r_size;
    logic        r_sgn;
    logic [31:0] r_addr;

    // Asynchronous reset: outputs must clear before any clock edge.
    #2 rst = 1'b0; req_valid_i = 1'b1;
    #1;
    check("rst_ready", {31'h0, req_ready_o}, 32'h1);
    check("rst_done", {31'h0, done_o}, 32'h0);
    check("rst_err", {31'h0, err_o}, 32'h0);
    check("rst_rdata", rdata_o, 32'h0);
    check("rst_we", {31'h0, ram_we_o}, 32'h0);
    check("rst_addr", ram_addr_o, 32'h0);
    check("rst_wdata", {24'h0, ram_wdata_o}, 32'h0);
    check("rst_stall", {31'h0, stall_o}, 32'h0);
    req_valid_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b1;

    preload(32'h100, 8'h78); preload(32'h101, 8'h56);
    preload(32'h102, 8'h34); preload(32'h103, 8'h12);
    preload(32'h7, 8'h80);
    preload(32'hFFFF_FFFE, 8'h11); preload(32'hFFFF_FFFF, 8'h22);
    preload(32'h0, 8'h33); preload(32'h1, 8'h44);
    preload(32'h402, 8'h55); preload(32'h403, 8'h66);

    do_op(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 1'b0);         // word load
    do_op(1'b0, 2'd0, 1'b1, 32'h7, 32'h0, 1'b0);           // signed byte
    do_op(1'b0, 2'd0, 1'b0, 32'h7, 32'h0, 1'b0);           // unsigned byte
    do_op(1'b1, 2'd1, 1'b0, 32'h202, 32'h1234_BEEF, 1'b0); // half store
    do_op(1'b0, 2'd1, 1'b0, 32'h202, 32'h0, 1'b0);         // half load
    do_op(1'b0, 2'd2, 1'b0, 32'hFFFF_FFFE, 32'h0, 1'b0);   // wrapping word
    do_op(1'b0, 2'd3, 1'b1, 32'h100, 32'h0, 1'b1);         // held request
    do_op(1'b0, 2'd3, 1'b1, 32'h100, 32'h0, 1'b0);         // accepted right after

    // Reset in the middle of a word store, after two bytes went out.
    @(posedge clk); #1;
    req_valid_i = 1'b1; req_we_i = 1'b1; req_size_i = 2'd2;
    req_signed_i = 1'b0; req_addr_i = 32'h400; req_wdata_i = 32'hA1B2_C3D4;
    @(posedge clk); #1; req_valid_i = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("mid_store_we", {31'h0, ram_we_o}, 32'h1);
    rst = 1'b0;
    #1;
    check("abort_we", {31'h0, ram_we_o}, 32'h0);
    check("abort_ready", {31'h0, req_ready_o}, 32'h1);
    check("abort_stall", {31'h0, stall_o}, 32'h0);
    check("abort_addr", ram_addr_o, 32'h0);
    check("abort_rdata", rdata_o, 32'h0);
    exp_rdata = 32'h0;
    ref_mem[32'h400] = 8'hD4;
    ref_mem[32'h401] = 8'hC3;
    @(negedge clk); rst = 1'b1;
    do_op(1'b0, 2'd2, 1'b0, 32'h400, 32'h0, 1'b0);         // only 2 bytes landed

    // Randomized traffic over a small window and the top of the address space.
    for (int i = 0; i < 40; i++) begin
      r_we   = 1'($urandom);
      r_size = 2'($urandom);
      r_sgn  = 1'($urandom);
      r_addr = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC + $urandom_range(0, 3)
                                           : 32'h300 + $urandom_range(0, 15);
      do_op(r_we, r_size, r_sgn, r_addr, $urandom, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
